spi_slave: RTL and testbench
============================

# spi_slave

Memory-mapped SPI slave (responder) peripheral, Mode 0 only (CPOL=0, CPHA=0), 8-bit frames. It lets the SoC act as the target of an external SPI master. It sits on the same peripheral bus as the SPI master and mirrors its register style. Asynchronous SCLK, CS_N and MOSI are synchronized into `clk`, and all shifting runs in the `clk` domain. One TX holding byte and one RX holding byte are buffered, with underrun/overrun flags and an interrupt.

## Interface
- `SPI_SLAVE_BASE_ADDR`, default 32'h40006000: block decodes when `mem_addr[31:8] == SPI_SLAVE_BASE_ADDR[31:8]`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_addr`  in  32  bus address; offset is `mem_addr[7:0]`.
- `mem_wdata`  in  32  write data.
- `mem_we`  in  1  write strobe, single cycle.
- `mem_re`  in  1  read strobe, single cycle.
- `mem_rdata`  out  32  read data, combinational; 0 when not selected or `mem_re`=0.
- `spi_cs_n`  in  1  chip select from the external master, active-low, async.
- `spi_sclk`  in  1  SPI clock, async; frequency ≤ clk/8.
- `spi_mosi`  in  1  master-out data, async.
- `spi_miso`  out  1  slave-out data, registered; reset 1'b0.
- `spi_miso_oe`  out  1  pad output enable; reset 0.
- `irq`  out  1  level interrupt, registered; reset 0.

## Operation
- Registers. All are reset to 0 except TX_EMPTY, which resets to 1.
  - CTRL 0x00 (R/W): bit0 EN, bit1 IRQ_EN.
  - STATUS 0x04: bit0 BUSY (RO, CS active), bit1 RX_VALID (RO), bit2 TX_EMPTY (RO), bit3 RX_OVERRUN (W1C), bit4 TX_UNDERRUN (W1C).
  - TX_DATA 0x08 (WO): write loads the TX holding byte from `[7:0]` and clears TX_EMPTY. Writing while the holding byte is full overwrites it.
  - RX_DATA 0x0C (RO): returns the RX holding byte. Any `mem_re` at this offset clears RX_VALID on the next edge.
- Synchronization: 2-flop synchronizers on `spi_cs_n`, `spi_sclk` and `spi_mosi`, plus one delay flop on `spi_cs_n` and `spi_sclk` for edge detect. Edges are detected 3 clk after the pin edge.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: bit_cnt=0, `spi_miso_oe`=0. If EN=1 and a CS falling edge is detected, go to LOAD.
  - LOAD (1 cycle):
    - If TX_EMPTY=0, the shift register takes the TX holding byte and TX_EMPTY is set.
    - Otherwise the shift register takes 8'hFF and TX_UNDERRUN is set.
    - `spi_miso` takes shift[7] and `spi_miso_oe`=1. Go to SHIFT.
  - SHIFT, on a synced SCLK rising edge: rx_shift <= {rx_shift[6:0], mosi_sync} and bit_cnt++.
    - When bit_cnt reaches 8 and RX_VALID=0: the RX holding byte takes the assembled byte and RX_VALID is set.
    - When bit_cnt reaches 8 and RX_VALID=1: the new byte is discarded and RX_OVERRUN is set.
    - bit_cnt returns to 0.
  - SHIFT, on a synced SCLK falling edge:
    - If bit_cnt ≠ 0: tx shifts left and `spi_miso` takes the next bit.
    - If bit_cnt = 0 (byte boundary): reload from the TX holding byte, or 8'hFF with underrun, exactly as in LOAD. This supports back-to-back bytes within one CS.
  - A CS rising edge in any state returns to IDLE on the next edge. A partial byte is discarded with no RX_VALID and no flag; `spi_miso_oe` drops and `spi_miso` goes to 0.
- EN=0 forces IDLE immediately, including mid-frame. Holding registers and flags are kept.
- `irq` = IRQ_EN & (RX_VALID | RX_OVERRUN | TX_UNDERRUN), registered.
- Simultaneous events:
  - An RX_DATA read in the same cycle as a new byte completing: the read returns the old byte. RX_VALID remains 1 with the new byte, and there is no overrun.
  - A TX_DATA write in the same cycle as a LOAD or boundary reload: the reload uses the old holding state, then the write takes effect and TX_EMPTY=0.
  - W1C on the same cycle a flag sets: the set wins.

## Timing
- CS fall to `spi_miso` valid: 4 clk (3 detect + LOAD).
- SCLK fall to the next `spi_miso` bit: 4 clk.
- Both fit within the half-period at ≤ clk/8.
- 8th SCLK rise to RX_VALID=1: 4 clk. `irq` follows 1 clk later.
- Register writes take effect on the next `clk` edge. Reads are zero-latency combinational.
- Reset mid-frame: every register and output returns to its reset value asynchronously.

## Structure
- Package `spi_slave_pkg`: register offsets (0x00–0x0C), STATUS/CTRL bit indices, FSM state encoding, idle fill byte 8'hFF.
- Sub-module `spi_slave_sync`: 2-flop synchronizer plus delay flop, outputting the synced level and rise/fall pulses. It is instantiated for SCLK and CS; MOSI uses the level only.

## Test plan
- EN=1, TX_DATA=0xA5, master sends 0x3C at clk/8 → MISO shifts 0xA5 MSB first; RX_DATA=0x3C, RX_VALID=1, TX_EMPTY=1.
- No TX write, master sends one byte → MISO=0xFF, TX_UNDERRUN=1, `irq`=1 with IRQ_EN; W1C 0x10 clears it.
- Two bytes 0x11, 0x22 without reading RX → RX_DATA=0x11, RX_OVERRUN=1; a read then clears RX_VALID.
- CS deasserted after 5 bits → FSM returns to IDLE, RX_VALID stays 0, `spi_miso_oe`=0; the next full frame is received correctly.
- Back-to-back under one CS: TX writes 0x5A, then 0xC3 after TX_EMPTY → MISO 0x5A then 0xC3 with no gap.
- `rst_n` low mid-frame → all outputs reset; TX_EMPTY=1 and the rest of STATUS=0.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: register map, bit positions,
// FSM encoding and the fill byte sent when no TX data is queued.
package spi_slave_pkg;

  localparam int DATA_W = 8;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_TX_DATA = 8'h08;
  localparam logic [7:0] OFF_RX_DATA = 8'h0C;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STAT_BUSY        = 0;
  localparam int STAT_RX_VALID    = 1;
  localparam int STAT_TX_EMPTY    = 2;
  localparam int STAT_RX_OVERRUN  = 3;
  localparam int STAT_TX_UNDERRUN = 4;

  localparam logic [DATA_W-1:0] FILL_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer with an extra delay flop, giving the synced level
// and single-cycle rise/fall pulses in the clk domain.
module spi_slave_sync #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic dly_p2;

  // Resynchronize the pin, then keep one older sample for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= INIT;
      sync_p1 <= INIT;
      dly_p2  <= INIT;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      dly_p2  <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~dly_p2;
  assign fall  = ~sync_p1 & dly_p2;

endmodule

// File: rtl/spi_slave.sv
// Memory-mapped Mode-0 SPI slave with one TX and one RX holding byte,
// underrun/overrun flags and a level interrupt. All SPI pins are
// resampled into clk and every shift happens in the clk domain.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter logic [31:0] SPI_SLAVE_BASE_ADDR = 32'h40006000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic mosi_p0, mosi_p1;

  logic                en, irq_en;
  logic [DATA_W-1:0]   tx_hold, rx_hold;
  logic                tx_empty, rx_valid, rx_overrun, tx_underrun;

  state_t              state;
  logic [2:0]          bit_cnt;
  logic [DATA_W-1:0]   tx_shift, rx_shift;

  logic                sel, wr_ctrl, wr_status, wr_tx, rd_rx;
  logic [DATA_W-1:0]   reload_byte, rx_byte;
  logic                reload_evt, byte_done;
  logic                unused_bits;

  spi_slave_sync #(.INIT(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_slave_sync #(.INIT(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // MOSI only needs its level; same depth as SCLK so data and edge line up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      mosi_p0 <= spi_mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  assign sel       = (mem_addr[31:8] == SPI_SLAVE_BASE_ADDR[31:8]);
  assign wr_ctrl   = sel & mem_we & (mem_addr[7:0] == OFF_CTRL);
  assign wr_status = sel & mem_we & (mem_addr[7:0] == OFF_STATUS);
  assign wr_tx     = sel & mem_we & (mem_addr[7:0] == OFF_TX_DATA);
  assign rd_rx     = sel & mem_re & (mem_addr[7:0] == OFF_RX_DATA);

  // Shift-side events, shared by the FSM and the register block
  always_comb begin
    reload_byte = tx_empty ? FILL_BYTE : tx_hold;
    rx_byte     = {rx_shift[DATA_W-2:0], mosi_p1};
    reload_evt  = 1'b0;
    byte_done   = 1'b0;
    if (en && !cs_rise) begin
      reload_evt = (state == S_LOAD) ||
                   ((state == S_SHIFT) && sclk_fall && (bit_cnt == 3'd0));
      byte_done  = (state == S_SHIFT) && sclk_rise && (bit_cnt == 3'd7);
    end
  end

  // Frame FSM: load, shift out on SCLK fall, sample in on SCLK rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= 3'd0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else if (!en || cs_rise) begin
      state       <= S_IDLE;
      bit_cnt     <= 3'd0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bit_cnt     <= 3'd0;
          spi_miso    <= 1'b0;
          spi_miso_oe <= 1'b0;
          if (cs_fall) state <= S_LOAD;
        end
        S_LOAD: begin
          tx_shift    <= reload_byte;
          spi_miso    <= reload_byte[DATA_W-1];
          spi_miso_oe <= 1'b1;
          state       <= S_SHIFT;
        end
        S_SHIFT: begin
          if (sclk_rise) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
          end else if (sclk_fall) begin
            if (bit_cnt != 3'd0) begin
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              spi_miso <= tx_shift[DATA_W-2];
            end else begin
              tx_shift <= reload_byte;
              spi_miso <= reload_byte[DATA_W-1];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Control register, holding bytes and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en          <= 1'b0;
      irq_en      <= 1'b0;
      tx_hold     <= '0;
      tx_empty    <= 1'b1;
      rx_hold     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en     <= mem_wdata[CTRL_EN];
        irq_en <= mem_wdata[CTRL_IRQ_EN];
      end
      // A write landing on a reload cycle wins: the reload already used the old byte
      if (wr_tx) begin
        tx_hold  <= mem_wdata[DATA_W-1:0];
        tx_empty <= 1'b0;
      end else if (reload_evt) begin
        tx_empty <= 1'b1;
      end
      if (reload_evt && tx_empty)                        tx_underrun <= 1'b1;
      else if (wr_status && mem_wdata[STAT_TX_UNDERRUN]) tx_underrun <= 1'b0;
      // A read in the same cycle as completion frees the slot for the new byte
      if (byte_done && (!rx_valid || rd_rx)) begin
        rx_hold  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end
      if (byte_done && rx_valid && !rd_rx)              rx_overrun <= 1'b1;
      else if (wr_status && mem_wdata[STAT_RX_OVERRUN]) rx_overrun <= 1'b0;
    end
  end

  // Registered interrupt level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= irq_en & (rx_valid | rx_overrun | tx_underrun);
  end

  // Combinational read mux
  always_comb begin
    mem_rdata = '0;
    if (sel && mem_re) begin
      case (mem_addr[7:0])
        OFF_CTRL: begin
          mem_rdata[CTRL_EN]     = en;
          mem_rdata[CTRL_IRQ_EN] = irq_en;
        end
        OFF_STATUS: begin
          mem_rdata[STAT_BUSY]        = ~cs_level;
          mem_rdata[STAT_RX_VALID]    = rx_valid;
          mem_rdata[STAT_TX_EMPTY]    = tx_empty;
          mem_rdata[STAT_RX_OVERRUN]  = rx_overrun;
          mem_rdata[STAT_TX_UNDERRUN] = tx_underrun;
        end
        OFF_RX_DATA: mem_rdata[DATA_W-1:0] = rx_hold;
        default:     mem_rdata = '0;
      endcase
    end
  end

  assign unused_bits = ^{mem_wdata[31:8], sclk_level};

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: drives a Mode-0 master at clk/8 and the register
// bus, and compares against a byte-level behavioural model.
module tb_spi_slave;
  import spi_slave_pkg::*;

  localparam logic [31:0] BASE = 32'h40006000;
  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic [31:0] mem_rdata;
  logic        spi_cs_n = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0] m_tx_hold, m_rx_hold;
  logic       m_tx_empty, m_rx_valid, m_ovr, m_und, m_irq_en;

  logic [7:0] mo_bytes [4];
  logic [7:0] mi_bytes [4];
  logic [7:0] exp_mi   [4];

  spi_slave #(.SPI_SLAVE_BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
    @(negedge clk);
    mem_addr = BASE | 32'(off); mem_wdata = d; mem_we = 1'b1;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    mem_addr = a; mem_re = 1'b1;
    #1 d = mem_rdata;
    @(negedge clk);
    mem_re = 1'b0;
  endtask

  task automatic model_reset();
    m_tx_hold = 8'h00; m_rx_hold = 8'h00; m_tx_empty = 1'b1;
    m_rx_valid = 1'b0; m_ovr = 1'b0; m_und = 1'b0; m_irq_en = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] v);
    bus_write(OFF_TX_DATA, {24'h0, v});
    m_tx_hold = v; m_tx_empty = 1'b0;
  endtask

  task automatic w1c(input logic [31:0] v);
    bus_write(OFF_STATUS, v);
    if (v[3]) m_ovr = 1'b0;
    if (v[4]) m_und = 1'b0;
  endtask

  task automatic read_rx();
    logic [31:0] d;
    bus_read(BASE | 32'(OFF_RX_DATA), d);
    chk("rx_data", d, {24'h0, m_rx_hold});
    m_rx_valid = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] d;
    bus_read(BASE | 32'(OFF_STATUS), d);
    chk({tag, "_status"}, d, {27'h0, m_und, m_ovr, m_tx_empty, m_rx_valid, 1'b0});
    chk({tag, "_irq"}, {31'h0, irq}, {31'h0, m_irq_en & (m_rx_valid | m_ovr | m_und)});
    chk({tag, "_idle_pins"}, {30'h0, spi_miso_oe, spi_miso}, 32'h0);
  endtask

  // Byte-level view: one TX reload at frame start and after every full byte;
  // each full byte received goes to the holding byte or counts as overrun.
  task automatic model_frame(input int nbits, input bit mid_en, input logic [7:0] mid_v);
    int nfull;
    nfull = nbits / 8;
    for (int j = 0; j <= nfull; j++) begin
      if (m_tx_empty) begin
        exp_mi[j] = 8'hFF; m_und = 1'b1;
      end else begin
        exp_mi[j] = m_tx_hold; m_tx_empty = 1'b1;
      end
      if (j == 0 && mid_en) begin
        m_tx_hold = mid_v; m_tx_empty = 1'b0;
      end
      if (j < nfull) begin
        if (!m_rx_valid) begin
          m_rx_hold = mo_bytes[j]; m_rx_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  endtask

  task automatic spi_frame(input int nbits, input bit mid_en, input logic [7:0] mid_v);
    @(negedge clk);
    spi_cs_n = 1'b0;
    spi_mosi = mo_bytes[0][7];
    for (int i = 0; i < nbits; i++) begin
      if (mid_en && i == 2) begin
        bus_write(OFF_TX_DATA, {24'h0, mid_v});
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      mi_bytes[i/8][7-(i%8)] = spi_miso;
      if (i == 0) chk("oe_active", {31'h0, spi_miso_oe}, 32'd1);
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
      if (i + 1 < nbits) spi_mosi = mo_bytes[(i+1)/8][7-((i+1)%8)];
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input int nbits, input bit mid_en,
                           input logic [7:0] mid_v);
    int nby;
    int rem;
    logic [7:0] mask;
    nby = (nbits + 7) / 8;
    rem = nbits % 8;
    model_frame(nbits, mid_en, mid_v);
    spi_frame(nbits, mid_en, mid_v);
    for (int j = 0; j < nby; j++) begin
      mask = (j == nby - 1 && rem != 0) ? (8'hFF << (8 - rem)) : 8'hFF;
      chk({tag, "_miso"}, {24'h0, mi_bytes[j] & mask}, {24'h0, exp_mi[j] & mask});
    end
    check_state(tag);
  endtask

  initial begin
    logic [31:0] d;
    int          r;
    int          nb;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    bus_read(BASE | 32'(OFF_CTRL), d);
    chk("reset_ctrl", d, 32'h0);
    check_state("reset");
    bus_read(32'h40007004, d);
    mem_addr = '0;
    chk("unselected_read", d, 32'h0);

    bus_write(OFF_CTRL, 32'h3);
    m_irq_en = 1'b1;
    bus_read(BASE | 32'(OFF_CTRL), d);
    chk("ctrl_rw", d, 32'h3);

    // basic exchange
    tx_write(8'hA5);
    mo_bytes[0] = 8'h3C;
    run_frame("basic", 8, 1'b0, 8'h00);
    read_rx();
    w1c(32'h18);
    check_state("basic_clr");

    // underrun with no TX data
    mo_bytes[0] = 8'h96;
    run_frame("underrun", 8, 1'b0, 8'h00);
    read_rx();
    w1c(32'h10);
    check_state("underrun_clr");

    // two bytes without reading RX
    mo_bytes[0] = 8'h11; mo_bytes[1] = 8'h22;
    run_frame("overrun", 16, 1'b0, 8'h00);
    read_rx();
    check_state("overrun_read");
    w1c(32'h18);

    // aborted frame then a full one
    mo_bytes[0] = 8'hE7;
    run_frame("partial", 5, 1'b0, 8'h00);
    tx_write(8'h81);
    mo_bytes[0] = 8'h4D;
    run_frame("after_partial", 8, 1'b0, 8'h00);
    read_rx();

    // back-to-back bytes under one CS with a refill during the first byte
    tx_write(8'h5A);
    mo_bytes[0] = 8'h01; mo_bytes[1] = 8'h02;
    run_frame("b2b", 16, 1'b1, 8'hC3);
    read_rx();
    w1c(32'h18);

    // randomized traffic
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      if ($urandom_range(0, 2) == 0 && m_rx_valid) read_rx();
      r = $urandom_range(0, 4);
      case (r)
        0: nb = 8;
        1: nb = 16;
        2: nb = 24;
        3: nb = 5;
        default: nb = 13;
      endcase
      for (int j = 0; j < 4; j++) mo_bytes[j] = 8'($urandom);
      run_frame("rand", nb, 1'b0, 8'h00);
      if ($urandom_range(0, 1) == 1) w1c({27'h0, 2'($urandom), 3'b000});
    end

    // reset in the middle of a frame
    tx_write(8'hF0);
    @(negedge clk);
    spi_cs_n = 1'b0;
    spi_mosi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
    chk("pre_reset_oe", {31'h0, spi_miso_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pins", {29'h0, irq, spi_miso_oe, spi_miso}, 32'h0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_read(BASE | 32'(OFF_CTRL), d);
    chk("post_reset_ctrl", d, 32'h0);
    check_state("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
